sb_tx_scheduler: RTL and testbench
==================================

Name: sb_tx_scheduler

Overview:
- Arbitrates between N sideband message sources and sequences one at a time into the SB TX serializer, the transmit mirror of the RX deserializer path.
- Each packet is a 64-bit header plus an optional 64-bit data word.
- Enforces a programmable idle gap between packets, as the UCIe sideband link requires.
- Sits in the SB digital domain, between the message encoders (LTSM, RDI/FDI, register access) and the analog serializer model.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WORD_W, 64, sideband word width.
- GAP_CYCLES, 4, number of i_clk cycles of idle after the final word of a packet completes (0 = no gap).

Ports:
- i_clk  in  1  SB digital clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  N_REQ  per-requester packet request (level).
- i_hdr  in  N_REQ*WORD_W  per-requester header word, slice k = requester k.
- i_data  in  N_REQ*WORD_W  per-requester data word.
- i_has_data  in  N_REQ  requester packet carries a data word.
- o_gnt  out  N_REQ  one-hot, one-cycle pulse: request accepted.
- o_ser_data  out  WORD_W  word presented to the serializer.
- o_ser_valid  out  1  o_ser_data is valid; held until acknowledged.
- i_ser_ack  in  1  serializer has latched o_ser_data.
- i_ser_done  in  1  one-cycle pulse: serializer finished shifting the current word.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, any time, including mid-packet):
  - FSM goes to IDLE, round-robin pointer to 0, gap counter to 0.
  - o_gnt = 0, o_ser_data = 0, o_ser_valid = 0, o_busy = 0.
  - The in-flight packet is dropped and is not replayed.
- Requester contract: hdr, data and has_data stay stable while req is high until gnt is seen. After gnt, req may drop or stay high for a new packet.
- FSM states: IDLE, LOAD_HDR, WAIT_HDR, LOAD_DATA, WAIT_DATA, GAP.
- IDLE:
  - If any i_req is high, the arbiter picks a winner k.
  - At that edge: latch hdr, data and has_data of k; pulse o_gnt[k] in the next cycle; go to LOAD_HDR.
  - Pointer becomes (k+1) mod N_REQ.
  - Grant latency is 1 cycle from req sampled to gnt high.
- LOAD_HDR: o_ser_valid = 1, o_ser_data = latched hdr. When i_ser_ack is sampled high, o_ser_valid drops next cycle and the FSM goes to WAIT_HDR.
- WAIT_HDR: on i_ser_done, go to LOAD_DATA if has_data, else to GAP.
- LOAD_DATA / WAIT_DATA: same handshake using the latched data word. On i_ser_done, go to GAP.
- i_ser_done is ignored in IDLE, LOAD_* and GAP; a done pulse coincident with ack in a LOAD_* state is discarded.
- i_ser_ack is ignored outside LOAD_* states.
- GAP:
  - Counter loads GAP_CYCLES-1 on entry and decrements each cycle; the FSM returns to IDLE when it reaches 0.
  - If GAP_CYCLES = 0, WAIT_* goes directly to IDLE.
  - Requests are not sampled during GAP, so the minimum packet-to-packet spacing is GAP_CYCLES + 1 cycles.
- o_ser_data holds its last value while o_ser_valid = 0.
- o_busy = (state != IDLE).
- Arbitration is round-robin: search starts at the pointer and wraps modulo N_REQ. Every requester holding req is served within N_REQ packets.

Optional Feature:
- Macro SB_TX_PRIORITY_EN.
- Defined: requester 0 has fixed highest priority (stall/ack messages). If i_req[0] is high in IDLE it always wins, and the pointer is not updated on a requester-0 win. Requesters 1..N_REQ-1 round-robin among themselves.
- Undefined: pure round-robin over all N_REQ requesters.

Decomposition:
- Package sb_tx_pkg holds:
  - the state enum sb_tx_state_e;
  - SB_WORD_W = 64;
  - a helper function for the one-hot-to-index conversion.
- Sub-module sb_rr_arbiter holds the combinational round-robin pick from req vector and pointer, outputting winner index and valid. It contains the SB_TX_PRIORITY_EN logic.
- The scheduler FSM, data latches and gap counter stay in the top module.

Test Plan:
- Reset mid-packet: assert i_rst_n = 0 while in WAIT_DATA -> o_ser_valid = 0, o_busy = 0, o_gnt = 0 immediately. After release, req[2] gets gnt[2] one cycle after sampling.
- Single header-only packet: req[1] = 1, hdr = 64'hA5A5_0000_0000_0001, has_data = 0, ack 3 cycles later, done 66 cycles later -> one word on o_ser_data, GAP held 4 cycles, then IDLE.
- Header + data packet: has_data = 1, data = 64'hDEAD_BEEF_0000_0002 -> two valid/ack handshakes in order hdr then data, and gnt pulses exactly once.
- Round-robin fairness: req = 4'b1111 held for 8 packets, N_REQ = 4 -> grant order 0,1,2,3,0,1,2,3.
- Coincident ack + done in LOAD_HDR -> done discarded, FSM waits in WAIT_HDR for the next done pulse.
- SB_TX_PRIORITY_EN defined: req = 4'b1111 with req[0] re-asserted after every grant -> grant order 0,0,0... Drop req[0] -> order 1,2,3,1.

Source files
------------

// File: rtl/sb_tx_pkg.sv
// sb_tx_pkg: shared state type, word width and index helper for the sideband TX scheduler
package sb_tx_pkg;
  localparam int SB_WORD_W = 64;
  typedef enum logic [2:0] {IDLE, LOAD_HDR, WAIT_HDR, LOAD_DATA, WAIT_DATA, GAP} sb_tx_state_e;
  // position of the set bit in a one-hot vector of up to 8 requesters (0 when empty)
  function automatic logic [2:0] sb_onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction
endpackage

// File: rtl/sb_rr_arbiter.sv
// sb_rr_arbiter: combinational round-robin pick; SB_TX_PRIORITY_EN gives requester 0 fixed top priority
module sb_rr_arbiter import sb_tx_pkg::*; #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic [$clog2(N_REQ)-1:0] ptr_nxt,
  output logic                     valid
);
  localparam int IDX_W = $clog2(N_REQ);
  logic             win0;
  logic [N_REQ-1:0] cand, hi, pick, oh;
`ifdef SB_TX_PRIORITY_EN
  assign win0 = req[0];
  assign cand = {req[N_REQ-1:1], 1'b0};
`else
  assign win0 = 1'b0;
  assign cand = req;
`endif
  // requesters at or above the pointer first, otherwise wrap to the lowest one
  assign hi      = cand & ({N_REQ{1'b1}} << ptr);
  assign pick    = |hi ? hi : cand;
  assign oh      = pick & (~pick + N_REQ'(1));
  assign idx     = win0 ? '0 : IDX_W'(sb_onehot_to_idx(8'(oh)));
  assign valid   = |req;
  assign ptr_nxt = win0 ? ptr : idx == IDX_W'(N_REQ - 1) ? '0 : idx + IDX_W'(1);
endmodule

// File: rtl/sb_tx_scheduler.sv
// sb_tx_scheduler: sequences header/data words of N sideband requesters into the serializer with an idle gap (option: SB_TX_PRIORITY_EN)
module sb_tx_scheduler import sb_tx_pkg::*; #(
  parameter int N_REQ      = 4,
  parameter int WORD_W     = SB_WORD_W,
  parameter int GAP_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*WORD_W-1:0] i_hdr,
  input  logic [N_REQ*WORD_W-1:0] i_data,
  input  logic [N_REQ-1:0]        i_has_data,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [WORD_W-1:0]       o_ser_data,
  output logic                    o_ser_valid,
  input  logic                    i_ser_ack,
  input  logic                    i_ser_done,
  output logic                    o_busy
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam sb_tx_state_e END_ST = GAP_CYCLES == 0 ? IDLE : GAP;
  sb_tx_state_e      state;
  logic [IDX_W-1:0]  ptr, idx, ptr_nxt;
  logic              arb_valid, has_data_q;
  logic [WORD_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt;
  sb_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (i_req),
    .ptr     (ptr),
    .idx     (idx),
    .ptr_nxt (ptr_nxt),
    .valid   (arb_valid)
  );
  assign o_busy = state != IDLE;
  // packet FSM: grant and latch in IDLE, valid/ack per word, done to advance, then idle gap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      o_gnt       <= '0;
      o_ser_data  <= '0;
      o_ser_valid <= 1'b0;
      data_q      <= '0;
      has_data_q  <= 1'b0;
    end else begin
      o_gnt <= '0;
      case (state)
        IDLE: if (arb_valid) begin
          state       <= LOAD_HDR;
          ptr         <= ptr_nxt;
          o_gnt       <= N_REQ'(1) << idx;
          o_ser_data  <= i_hdr[idx*WORD_W +: WORD_W];
          o_ser_valid <= 1'b1;
          data_q      <= i_data[idx*WORD_W +: WORD_W];
          has_data_q  <= i_has_data[idx];
        end
        LOAD_HDR, LOAD_DATA: if (i_ser_ack) begin
          o_ser_valid <= 1'b0;
          state       <= state == LOAD_HDR ? WAIT_HDR : WAIT_DATA;
        end
        WAIT_HDR: if (i_ser_done) begin
          if (has_data_q) begin
            state       <= LOAD_DATA;
            o_ser_data  <= data_q;
            o_ser_valid <= 1'b1;
          end else begin
            state <= END_ST;
            cnt   <= GAP_LD;
          end
        end
        WAIT_DATA: if (i_ser_done) begin
          state <= END_ST;
          cnt   <= GAP_LD;
        end
        GAP: if (cnt == '0) state <= IDLE; else cnt <= cnt - CNT_W'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sb_tx_scheduler.sv
// tb_sb_tx_scheduler: randomized self-checking bench against a round-robin reference model
`timescale 1ns/1ps
module tb_sb_tx_scheduler;
  localparam int N = 4, W = 64, GAPC = 4;
`ifdef SB_TX_PRIORITY_EN
  localparam bit PRI = 1'b1;
`else
  localparam bit PRI = 1'b0;
`endif
  logic           i_clk = 1'b0, i_rst_n = 1'b0;
  logic [N-1:0]   i_req = '0, i_has_data = '0, o_gnt;
  logic [N*W-1:0] i_hdr = '0, i_data = '0;
  logic [W-1:0]   o_ser_data;
  logic           o_ser_valid, o_busy, i_ser_ack = 1'b0, i_ser_done = 1'b0;
  int n_cmp = 0, n_err = 0, mptr = 0;

  always #5 i_clk = ~i_clk;

  sb_tx_scheduler #(.N_REQ(N), .WORD_W(W), .GAP_CYCLES(GAPC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_hdr(i_hdr), .i_data(i_data),
    .i_has_data(i_has_data), .o_gnt(o_gnt), .o_ser_data(o_ser_data), .o_ser_valid(o_ser_valid),
    .i_ser_ack(i_ser_ack), .i_ser_done(i_ser_done), .o_busy(o_busy)
  );

  // reference arbitration: first requester found from the pointer onward, modulo N
  task automatic model_pick(input logic [N-1:0] r, output int k);
    k = -1;
    if (PRI && r[0]) begin
      k = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      int j;
      j = (mptr + i) % N;
      if (k < 0 && r[j] && !(PRI && j == 0)) k = j;
    end
    if (k >= 0) mptr = (k + 1) % N;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0; i_req = '0; i_ser_ack = 1'b0; i_ser_done = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    mptr = 0;
  endtask

  // plays the serializer for one packet and reports what the DUT presented
  task automatic serve(input int ack_dly, input int done_dly, input bit drop,
                       output logic [N-1:0] g, output logic [N-1:0] sreq, output int lat,
                       output logic [W-1:0] w0, output logic [W-1:0] w1, output int nw,
                       output int gap, output bit hs_ok, output int ngnt);
    logic [W-1:0] cur;
    g = '0; sreq = '0; lat = 0; w0 = '0; w1 = '0; nw = 0; gap = 0; hs_ok = 1'b1; ngnt = 0;
    while (lat < 200) begin
      sreq = i_req;
      @(negedge i_clk);
      lat++;
      if (o_gnt != '0) break;
    end
    g = o_gnt;
    if (g == '0) return;
    ngnt = 1;
    if (drop) i_req = i_req & ~g;
    while (o_ser_valid && nw < 2) begin
      cur = o_ser_data;
      if (nw == 0) w0 = cur; else w1 = cur;
      nw++;
      repeat (ack_dly) begin
        @(negedge i_clk);
        if (!o_ser_valid || o_ser_data !== cur) hs_ok = 1'b0;
        if (o_gnt != '0) ngnt++;
      end
      i_ser_ack = 1'b1;
      @(negedge i_clk);
      i_ser_ack = 1'b0;
      if (o_ser_valid) hs_ok = 1'b0;
      if (o_gnt != '0) ngnt++;
      repeat (done_dly) begin
        @(negedge i_clk);
        if (o_ser_valid || !o_busy) hs_ok = 1'b0;
        if (o_gnt != '0) ngnt++;
      end
      i_ser_done = 1'b1;
      @(negedge i_clk);
      i_ser_done = 1'b0;
      if (o_gnt != '0) ngnt++;
    end
    while (o_busy && gap < 100) begin
      if (o_ser_valid) hs_ok = 1'b0;
      gap++;
      @(negedge i_clk);
      if (o_gnt != '0) ngnt++;
    end
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_asserted got %b exp 0", o_busy); end
    do_reset();
    n_cmp++; if (o_gnt !== '0) begin n_err++; $display("FAIL reset_gnt got %b exp 0", o_gnt); end
    n_cmp++; if (o_ser_data !== '0) begin n_err++; $display("FAIL reset_ser_data got %h exp 0", o_ser_data); end
    n_cmp++; if (o_ser_valid !== 1'b0) begin n_err++; $display("FAIL reset_ser_valid got %b exp 0", o_ser_valid); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", o_busy); end
  endtask

  task automatic test_single_hdr();
    logic [N-1:0] g, sreq;
    logic [W-1:0] w0, w1;
    int lat, nw, gap, ngnt, k;
    bit hs;
    i_hdr[1*W +: W] = 64'hA5A5_0000_0000_0001;
    i_has_data[1] = 1'b0;
    i_req = 4'b0010;
    serve(3, 66, 1'b1, g, sreq, lat, w0, w1, nw, gap, hs, ngnt);
    model_pick(sreq, k);
    n_cmp++; if (g !== N'(1) << k) begin n_err++; $display("FAIL single_gnt got %b exp %b", g, N'(1) << k); end
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL single_latency got %0d exp 1", lat); end
    n_cmp++; if (nw !== 1) begin n_err++; $display("FAIL single_words got %0d exp 1", nw); end
    n_cmp++; if (w0 !== 64'hA5A5_0000_0000_0001) begin n_err++; $display("FAIL single_hdr got %h exp a5a5000000000001", w0); end
    n_cmp++; if (gap !== GAPC) begin n_err++; $display("FAIL single_gap got %0d exp %0d", gap, GAPC); end
    n_cmp++; if (hs !== 1'b1) begin n_err++; $display("FAIL single_handshake got %b exp 1", hs); end
  endtask

  task automatic test_hdr_data();
    logic [N-1:0] g, sreq;
    logic [W-1:0] w0, w1, h;
    int lat, nw, gap, ngnt, k;
    bit hs;
    h = {$urandom, $urandom};
    i_hdr[2*W +: W] = h;
    i_data[2*W +: W] = 64'hDEAD_BEEF_0000_0002;
    i_has_data[2] = 1'b1;
    i_req = 4'b0100;
    serve(1, 5, 1'b1, g, sreq, lat, w0, w1, nw, gap, hs, ngnt);
    model_pick(sreq, k);
    n_cmp++; if (g !== N'(1) << k) begin n_err++; $display("FAIL hd_gnt got %b exp %b", g, N'(1) << k); end
    n_cmp++; if (ngnt !== 1) begin n_err++; $display("FAIL hd_gnt_pulses got %0d exp 1", ngnt); end
    n_cmp++; if (nw !== 2) begin n_err++; $display("FAIL hd_words got %0d exp 2", nw); end
    n_cmp++; if (w0 !== h) begin n_err++; $display("FAIL hd_first_word got %h exp %h", w0, h); end
    n_cmp++; if (w1 !== 64'hDEAD_BEEF_0000_0002) begin n_err++; $display("FAIL hd_second_word got %h exp deadbeef00000002", w1); end
    n_cmp++; if (gap !== GAPC) begin n_err++; $display("FAIL hd_gap got %0d exp %0d", gap, GAPC); end
    n_cmp++; if (hs !== 1'b1) begin n_err++; $display("FAIL hd_handshake got %b exp 1", hs); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g, sreq;
    logic [W-1:0] w0, w1;
    int lat, nw, gap, ngnt, k;
    bit hs;
    do_reset();
    for (int i = 0; i < N; i++) begin
      i_hdr[i*W +: W] = {$urandom, $urandom};
      i_data[i*W +: W] = {$urandom, $urandom};
      i_has_data[i] = 1'($urandom_range(0, 1));
    end
    i_req = '1;
    for (int p = 0; p < 2 * N; p++) begin
      serve($urandom_range(0, 2), $urandom_range(0, 3), 1'b0, g, sreq, lat, w0, w1, nw, gap, hs, ngnt);
      model_pick(sreq, k);
      if (p == 2 * N - 1) i_req = '0;
      n_cmp++; if (g !== N'(1) << k) begin n_err++; $display("FAIL rr_order[%0d] got %b exp %b", p, g, N'(1) << k); end
      n_cmp++; if (w0 !== i_hdr[k*W +: W]) begin n_err++; $display("FAIL rr_hdr[%0d] got %h exp %h", p, w0, i_hdr[k*W +: W]); end
      n_cmp++; if (nw !== 1 + int'(i_has_data[k])) begin n_err++; $display("FAIL rr_words[%0d] got %0d exp %0d", p, nw, 1 + int'(i_has_data[k])); end
    end
  endtask

  task automatic test_coincident();
    int gap;
    i_hdr[0 +: W] = {$urandom, $urandom};
    i_has_data[0] = 1'b0;
    i_req = 4'b0001;
    @(negedge i_clk);
    n_cmp++; if (o_gnt !== 4'b0001) begin n_err++; $display("FAIL co_gnt got %b exp 0001", o_gnt); end
    i_req = '0;
    i_ser_ack = 1'b1; i_ser_done = 1'b1;
    @(negedge i_clk);
    i_ser_ack = 1'b0; i_ser_done = 1'b0;
    n_cmp++; if (o_ser_valid !== 1'b0) begin n_err++; $display("FAIL co_valid_drop got %b exp 0", o_ser_valid); end
    repeat (8) @(negedge i_clk);
    n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL co_still_waiting got busy %b exp 1", o_busy); end
    i_ser_done = 1'b1;
    @(negedge i_clk);
    i_ser_done = 1'b0;
    gap = 0;
    while (o_busy && gap < 100) begin gap++; @(negedge i_clk); end
    n_cmp++; if (gap !== GAPC) begin n_err++; $display("FAIL co_gap got %0d exp %0d", gap, GAPC); end
    mptr = PRI ? mptr : 1;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] g, sreq;
    logic [W-1:0] w0, w1;
    int lat, nw, gap, ngnt, k;
    bit hs;
    i_hdr[1*W +: W] = {$urandom, $urandom};
    i_data[1*W +: W] = {$urandom, $urandom};
    i_has_data[1] = 1'b1;
    i_hdr[2*W +: W] = {$urandom, $urandom};
    i_has_data[2] = 1'b0;
    i_req = 4'b0010;
    @(negedge i_clk);
    i_req = '0;
    i_ser_ack = 1'b1; @(negedge i_clk); i_ser_ack = 1'b0;
    i_ser_done = 1'b1; @(negedge i_clk); i_ser_done = 1'b0;
    i_ser_ack = 1'b1; @(negedge i_clk); i_ser_ack = 1'b0;
    n_cmp++; if (o_busy !== 1'b1 || o_ser_data !== i_data[1*W +: W]) begin n_err++; $display("FAIL rm_in_wait_data got busy %b data %h exp 1 %h", o_busy, o_ser_data, i_data[1*W +: W]); end
    #2 i_rst_n = 1'b0;
    #1;
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rm_busy got %b exp 0", o_busy); end
    n_cmp++; if (o_ser_valid !== 1'b0 || o_gnt !== '0) begin n_err++; $display("FAIL rm_valid_gnt got %b %b exp 0 0", o_ser_valid, o_gnt); end
    n_cmp++; if (o_ser_data !== '0) begin n_err++; $display("FAIL rm_ser_data got %h exp 0", o_ser_data); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    mptr = 0;
    i_req = 4'b0100;
    serve(0, 2, 1'b1, g, sreq, lat, w0, w1, nw, gap, hs, ngnt);
    model_pick(sreq, k);
    n_cmp++; if (g !== N'(1) << k) begin n_err++; $display("FAIL rm_gnt got %b exp %b", g, N'(1) << k); end
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL rm_latency got %0d exp 1", lat); end
    n_cmp++; if (nw !== 1 || w0 !== i_hdr[2*W +: W]) begin n_err++; $display("FAIL rm_no_replay got %0d words %h exp 1 %h", nw, w0, i_hdr[2*W +: W]); end
  endtask

  task automatic test_random();
    logic [N-1:0] g, sreq;
    logic [W-1:0] w0, w1;
    int lat, nw, gap, ngnt, k;
    bit hs;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) if (!i_req[i]) begin
        i_hdr[i*W +: W] = {$urandom, $urandom};
        i_data[i*W +: W] = {$urandom, $urandom};
        i_has_data[i] = 1'($urandom_range(0, 1));
        i_req[i] = 1'($urandom_range(0, 1));
      end
      if (i_req == '0) i_req[$urandom_range(0, N - 1)] = 1'b1;
      serve($urandom_range(0, 3), $urandom_range(0, 6), 1'b1, g, sreq, lat, w0, w1, nw, gap, hs, ngnt);
      model_pick(sreq, k);
      n_cmp++; if (g !== N'(1) << k) begin n_err++; $display("FAIL rnd_gnt[%0d] got %b exp %b req %b", it, g, N'(1) << k, sreq); end
      n_cmp++; if (lat !== 1 || ngnt !== 1) begin n_err++; $display("FAIL rnd_gnt_timing[%0d] got lat %0d pulses %0d exp 1 1", it, lat, ngnt); end
      if (k >= 0) begin
        n_cmp++; if (w0 !== i_hdr[k*W +: W]) begin n_err++; $display("FAIL rnd_hdr[%0d] got %h exp %h", it, w0, i_hdr[k*W +: W]); end
        n_cmp++; if (nw !== 1 + int'(i_has_data[k])) begin n_err++; $display("FAIL rnd_words[%0d] got %0d exp %0d", it, nw, 1 + int'(i_has_data[k])); end
        if (i_has_data[k]) begin
          n_cmp++; if (w1 !== i_data[k*W +: W]) begin n_err++; $display("FAIL rnd_data[%0d] got %h exp %h", it, w1, i_data[k*W +: W]); end
        end
      end
      n_cmp++; if (gap !== GAPC || hs !== 1'b1) begin n_err++; $display("FAIL rnd_gap_hs[%0d] got gap %0d hs %b exp %0d 1", it, gap, hs, GAPC); end
    end
    i_req = '0;
  endtask

  task automatic test_priority();
    logic [N-1:0] g, sreq;
    logic [W-1:0] w0, w1;
    int lat, nw, gap, ngnt, k;
    bit hs;
    do_reset();
    i_has_data = '0;
    i_req = '1;
    for (int p = 0; p < 3; p++) begin
      serve(0, 1, 1'b0, g, sreq, lat, w0, w1, nw, gap, hs, ngnt);
      model_pick(sreq, k);
      n_cmp++; if (g !== 4'b0001 || g !== N'(1) << k) begin n_err++; $display("FAIL pri_req0[%0d] got %b exp 0001", p, g); end
    end
    i_req[0] = 1'b0;
    for (int p = 0; p < 4; p++) begin
      serve(0, 1, 1'b0, g, sreq, lat, w0, w1, nw, gap, hs, ngnt);
      model_pick(sreq, k);
      if (p == 3) i_req = '0;
      n_cmp++; if (g !== N'(1) << ((p % 3) + 1) || g !== N'(1) << k) begin n_err++; $display("FAIL pri_rr[%0d] got %b exp %b", p, g, N'(1) << ((p % 3) + 1)); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_hdr();
    test_hdr_data();
    test_round_robin();
    test_coincident();
    test_reset_mid();
    test_random();
    if (PRI) test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
